// File: rtl/exp_align.sv
// ---------------------------------------------------------------------------
// exp_align -- exponent alignment front end for a floating-point adder.
//
// Two-stage valid/ready pipeline:
//   S1 compares the exponents, chooses the big/small operand and forms the
//      exponent difference.
//   S2 right-shifts the small mantissa by that difference. It also produces
//      the guard bit and the sticky bit that are needed later for rounding.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake for the operand pair
//   exp_a, exp_b         biased unsigned exponents (EW bits)
//   mant_a, mant_b       mantissas including the hidden one (MW bits)
//   out_valid/out_ready  output handshake for the aligned result
//   exp_max              larger exponent
//   mant_big             mantissa of the larger-exponent operand, unshifted
//   mant_small           other mantissa shifted right by the exponent difference
//   guard, sticky        first bit shifted out / OR of all bits below it
//   swapped              1 when operand B has the strictly larger exponent
// ---------------------------------------------------------------------------
module exp_align #(
    parameter int MW = 12,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] exp_a,
    input  logic [EW-1:0] exp_b,
    input  logic [MW-1:0] mant_a,
    input  logic [MW-1:0] mant_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] exp_max,
    output logic [MW-1:0] mant_big,
    output logic [MW-1:0] mant_small,
    output logic          guard,
    output logic          sticky,
    output logic          swapped
);

    // Shift {m,0} right by d and return {mant_small, guard, sticky}.
    // A distance of MW+1 or more moves every bit past bit 0, so the result
    // saturates to zero with sticky = |m. Because of this, large
    // differences never wrap the shifter.
    function automatic logic [MW+1:0] align_shift(input logic [MW-1:0] m,
                                                   input logic [EW-1:0] d);
        logic [MW:0] ext;
        logic [MW:0] shifted;
        logic [MW:0] ones;
        logic        stk;
        ext  = {m, 1'b0};
        ones = '1;
        if (int'(d) > MW) begin
            shifted = '0;
            stk     = |m;
        end else begin
            shifted = ext >> d;
            stk     = |(ext & ~(ones << d));
        end
        return {shifted[MW:1], shifted[0], stk};
    endfunction

    logic          vld_p1_q, vld_p1_d;
    logic [EW-1:0] exp_max_p1_q, exp_max_p1_d;
    logic [EW-1:0] diff_p1_q, diff_p1_d;
    logic [MW-1:0] mant_big_p1_q, mant_big_p1_d;
    logic [MW-1:0] mant_min_p1_q, mant_min_p1_d;
    logic          swapped_p1_q, swapped_p1_d;

    logic          vld_p2_q, vld_p2_d;
    logic [EW-1:0] exp_max_q, exp_max_d;
    logic [MW-1:0] mant_big_q, mant_big_d;
    logic [MW-1:0] mant_small_q, mant_small_d;
    logic          guard_q, guard_d;
    logic          sticky_q, sticky_d;
    logic          swapped_q, swapped_d;

    logic adv_p1, adv_p2, swap_c;

    assign adv_p2   = !vld_p2_q || out_ready;
    assign adv_p1   = !vld_p1_q || adv_p2;
    assign in_ready = adv_p1;
    // Equal exponents keep operand A as the big one.
    assign swap_c   = (exp_b > exp_a);

    always_comb begin
        vld_p1_d      = vld_p1_q;
        exp_max_p1_d  = exp_max_p1_q;
        diff_p1_d     = diff_p1_q;
        mant_big_p1_d = mant_big_p1_q;
        mant_min_p1_d = mant_min_p1_q;
        swapped_p1_d  = swapped_p1_q;
        vld_p2_d      = vld_p2_q;
        exp_max_d     = exp_max_q;
        mant_big_d    = mant_big_q;
        mant_small_d  = mant_small_q;
        guard_d       = guard_q;
        sticky_d      = sticky_q;
        swapped_d     = swapped_q;

        // ---- S1: compare / swap / difference ----
        if (adv_p1) begin
            vld_p1_d = in_valid;
            if (in_valid) begin
                swapped_p1_d  = swap_c;
                exp_max_p1_d  = swap_c ? exp_b : exp_a;
                diff_p1_d     = swap_c ? (exp_b - exp_a) : (exp_a - exp_b);
                mant_big_p1_d = swap_c ? mant_b : mant_a;
                mant_min_p1_d = swap_c ? mant_a : mant_b;
            end
        end

        // ---- S2: shift, guard, sticky (output registers) ----
        if (adv_p2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                exp_max_d  = exp_max_p1_q;
                mant_big_d = mant_big_p1_q;
                swapped_d  = swapped_p1_q;
                {mant_small_d, guard_d, sticky_d} = align_shift(mant_min_p1_q, diff_p1_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q      <= 1'b0;
            exp_max_p1_q  <= '0;
            diff_p1_q     <= '0;
            mant_big_p1_q <= '0;
            mant_min_p1_q <= '0;
            swapped_p1_q  <= 1'b0;
            vld_p2_q      <= 1'b0;
            exp_max_q     <= '0;
            mant_big_q    <= '0;
            mant_small_q  <= '0;
            guard_q       <= 1'b0;
            sticky_q      <= 1'b0;
            swapped_q     <= 1'b0;
        end else begin
            vld_p1_q      <= vld_p1_d;
            exp_max_p1_q  <= exp_max_p1_d;
            diff_p1_q     <= diff_p1_d;
            mant_big_p1_q <= mant_big_p1_d;
            mant_min_p1_q <= mant_min_p1_d;
            swapped_p1_q  <= swapped_p1_d;
            vld_p2_q      <= vld_p2_d;
            exp_max_q     <= exp_max_d;
            mant_big_q    <= mant_big_d;
            mant_small_q  <= mant_small_d;
            guard_q       <= guard_d;
            sticky_q      <= sticky_d;
            swapped_q     <= swapped_d;
        end
    end

    assign out_valid  = vld_p2_q;
    assign exp_max    = exp_max_q;
    assign mant_big   = mant_big_q;
    assign mant_small = mant_small_q;
    assign guard      = guard_q;
    assign sticky     = sticky_q;
    assign swapped    = swapped_q;

endmodule

// File: tb/tb_exp_align.sv
// ---------------------------------------------------------------------------
// tb_exp_align -- self-checking bench for exp_align.
// Covers: reset state, directed alignment vectors, a randomized handshake
// stream against a behavioural model, a back-to-back stream with
// out_ready stalls, and reset applied while the pipeline is busy.
// ---------------------------------------------------------------------------
module tb_exp_align;
    localparam int MW = 12;
    localparam int EW = 8;

    typedef struct packed {
        logic [EW-1:0] em;
        logic [MW-1:0] mb;
        logic [MW-1:0] ms;
        logic          g;
        logic          s;
        logic          sw;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [EW-1:0] exp_a = '0, exp_b = '0;
    logic [MW-1:0] mant_a = '0, mant_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [EW-1:0] exp_max;
    logic [MW-1:0] mant_big, mant_small;
    logic          guard, sticky, swapped;

    int checks = 0;
    int errors = 0;

    exp_align #(.MW(MW), .EW(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_max(exp_max), .mant_big(mant_big), .mant_small(mant_small),
        .guard(guard), .sticky(sticky), .swapped(swapped)
    );

    always #5 clk = ~clk;

    res_t got;
    assign got = {exp_max, mant_big, mant_small, guard, sticky, swapped};

    // Reference: align by integer arithmetic on {mant_min, 0}.
    function automatic res_t model(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                                   input logic [MW-1:0] ma, input logic [MW-1:0] mbv);
        res_t r;
        logic [MW-1:0] mm;
        int d, v, q;
        r.sw = (eb > ea);
        r.em = r.sw ? eb : ea;
        r.mb = r.sw ? mbv : ma;
        mm   = r.sw ? ma : mbv;
        d    = r.sw ? int'(eb) - int'(ea) : int'(ea) - int'(eb);
        if (d > MW) begin
            r.ms = '0;
            r.g  = 1'b0;
            r.s  = (mm != 0);
        end else begin
            v    = int'(mm) * 2;
            q    = v / (1 << d);
            r.ms = MW'(q / 2);
            r.g  = (q % 2) == 1;
            r.s  = (v % (1 << d)) != 0;
        end
        return r;
    endfunction

    task automatic rand_operands();
        exp_a  = EW'($urandom);
        exp_b  = ($urandom_range(0, 1) == 1) ? EW'($urandom) : EW'(int'(exp_a) + $urandom_range(0, 30) - 15);
        mant_a = MW'($urandom) | 12'h800;
        mant_b = ($urandom_range(0, 3) == 0) ? MW'($urandom) : (MW'($urandom) | 12'h800);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || got !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b outputs=%h, required 0/0", out_valid, got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [EW-1:0] tea [6] = '{8'd130, 8'd100, 8'd127, 8'd140, 8'd140, 8'd255};
        logic [EW-1:0] teb [6] = '{8'd128, 8'd120, 8'd127, 8'd128, 8'd128, 8'd0};
        logic [MW-1:0] tma [6] = '{12'h800, 12'hFFF, 12'hA00, 12'hABC, 12'hABC, 12'h123};
        logic [MW-1:0] tmb [6] = '{12'hC03, 12'h900, 12'h801, 12'h800, 12'h801, 12'h000};
        res_t          texp [6] = '{
            {8'd130, 12'h800, 12'h300, 1'b1, 1'b1, 1'b0},
            {8'd120, 12'h900, 12'h000, 1'b0, 1'b1, 1'b1},
            {8'd127, 12'hA00, 12'h801, 1'b0, 1'b0, 1'b0},
            {8'd140, 12'hABC, 12'h000, 1'b1, 1'b0, 1'b0},
            {8'd140, 12'hABC, 12'h000, 1'b1, 1'b1, 1'b0},
            {8'd255, 12'h123, 12'h000, 1'b0, 1'b0, 1'b0}};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_a = tea[i]; exp_b = teb[i]; mant_a = tma[i]; mant_b = tmb[i];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed_latency%0d: out_valid=%b after 1 cycle, required 0", i, out_valid);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || got !== texp[i]) begin
                errors++;
                $display("FAIL directed%0d: out_valid=%b got=%h, required 1 %h", i, out_valid, got, texp[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        res_t q[$];
        res_t e;
        int   sent = 0, recv = 0, occ;
        bit   xfer;
        for (int cyc = 0; cyc < 3000 && (sent < 200 || q.size() > 0); cyc++) begin
            if (!in_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
                rand_operands();
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            occ  = q.size();
            xfer = 1'b0;
            checks++;
            if (in_ready !== !(occ == 2 && !out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready: got %b, required %b (occ %0d)", in_ready, !(occ == 2 && !out_ready), occ);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: output %h with nothing outstanding", got);
                end else begin
                    e = q.pop_front();
                    recv++;
                    if (got !== e) begin
                        errors++;
                        $display("FAIL rand_data: got %h, required %h", got, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(exp_a, exp_b, mant_a, mant_b));
                sent++;
                xfer = 1'b1;
            end
            @(posedge clk);
            #1;
            if (xfer) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (sent != 200 || recv != 200) begin
            errors++;
            $display("FAIL rand_count: sent %0d received %0d, required 200/200", sent, recv);
        end
    endtask

    task automatic test_back_to_back();
        res_t q[$];
        res_t e, hold;
        bit   held = 1'b0, xfer;
        int   sent = 0, recv = 0, occ;
        for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
            if (!in_valid && sent < 8) begin
                rand_operands();
                in_valid = 1'b1;
            end
            out_ready = (cyc % 3 == 0);
            @(negedge clk);
            occ  = q.size();
            xfer = 1'b0;
            checks++;
            if (in_ready !== !(occ == 2 && !out_ready)) begin
                errors++;
                $display("FAIL b2b_in_ready: got %b, required %b (occ %0d)", in_ready, !(occ == 2 && !out_ready), occ);
            end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || got !== hold) begin
                    errors++;
                    $display("FAIL b2b_hold: out_valid=%b got %h, required 1 %h", out_valid, got, hold);
                end
            end
            held = out_valid && !out_ready;
            hold = got;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: output %h with nothing outstanding", got);
                end else begin
                    e = q.pop_front();
                    recv++;
                    if (got !== e) begin
                        errors++;
                        $display("FAIL b2b_data%0d: got %h, required %h", recv, got, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(exp_a, exp_b, mant_a, mant_b));
                sent++;
                xfer = 1'b1;
            end
            @(posedge clk);
            #1;
            if (xfer) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (recv != 8) begin
            errors++;
            $display("FAIL b2b_count: received %0d, required 8", recv);
        end
    endtask

    task automatic test_midreset();
        res_t e;
        out_ready = 1'b0;
        rand_operands();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rand_operands();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_full: in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || got !== '0) begin
            errors++;
            $display("FAIL midrst_async: out_valid=%b outputs=%h, required 0/0", out_valid, got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL midrst_flushed%0d: out_valid=%b in_ready=%b, required 0/1", i, out_valid, in_ready);
            end
        end
        exp_a = 8'd90; exp_b = 8'd93; mant_a = 12'hF0F; mant_b = 12'h8A5;
        e = model(exp_a, exp_b, mant_a, mant_b);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL midrst_new: out_valid=%b got %h, required 1 %h", out_valid, got, e);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_tail: out_valid=%b, required 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
